// File: rtl/mu2cgra_lane_bridge.sv
// ---------------------------------------------------------------------------
// mu2cgra_lane_bridge
//
// Buffered bridge from the matrix-unit systolic output word (NUM_LANES lanes of
// LANE_W bits, valid/ready) to the CGRA tile-array input lanes.
//
// A DEPTH-entry word FIFO absorbs CGRA backpressure. Each stored word is
// optionally serialised into BEATS = NUM_LANES/OUT_LANES beats of OUT_LANES
// lanes each. A per-lane mask zeroes lanes at enqueue time. A saturating
// counter records cycles where a beat was offered but not taken.
//
// Ports
//   clk_in, reset_in      clock, asynchronous active-high reset
//   mu_dat/mu_vld/mu_rdy  matrix-unit word stream (lane i at [i*LANE_W +: LANE_W])
//   cfg_lane_mask         1 = lane passes, 0 = lane zeroed (sampled at push)
//   cgra_dat/vld/rdy      CGRA beat stream (lane j at [j*LANE_W +: LANE_W])
//   cgra_beat_idx         beat index of the current beat within its word
//   cgra_last             current beat is the final beat of its word
//   fifo_count            words currently held
//   stat_clr              synchronous clear of stall_cycles
//   stall_cycles          saturating count of cycles with cgra_vld & !cgra_rdy
//
// Notes
//   OUT_LANES must divide NUM_LANES and DEPTH must be >= 1.
//   FIFO storage is not reset; only pointers, occupancy, beat and stall state.
// ---------------------------------------------------------------------------

// Per-lane enqueue mask: passes the lane or forces it to zero.
module mu2cgra_lane_mask #(
    parameter int unsigned LANE_W = 16
) (
    input  logic [LANE_W-1:0] lane_i,
    input  logic              en_i,
    output logic [LANE_W-1:0] lane_o
);
    assign lane_o = en_i ? lane_i : '0;
endmodule

module mu2cgra_lane_bridge #(
    parameter  int unsigned NUM_LANES = 32,
    parameter  int unsigned LANE_W    = 16,
    parameter  int unsigned DEPTH     = 4,
    parameter  int unsigned OUT_LANES = 32,
    parameter  int unsigned STALL_W   = 32,
    localparam int unsigned BEATS     = NUM_LANES / OUT_LANES,
    localparam int unsigned BIDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic [NUM_LANES*LANE_W-1:0]   mu_dat,
    input  logic                          mu_vld,
    output logic                          mu_rdy,
    input  logic [NUM_LANES-1:0]          cfg_lane_mask,
    output logic [OUT_LANES*LANE_W-1:0]   cgra_dat,
    output logic                          cgra_vld,
    input  logic                          cgra_rdy,
    output logic [BIDX_W-1:0]             cgra_beat_idx,
    output logic                          cgra_last,
    output logic [CNT_W-1:0]              fifo_count,
    input  logic                          stat_clr,
    output logic [STALL_W-1:0]            stall_cycles
);

    localparam int unsigned WORD_W = NUM_LANES * LANE_W;
    localparam int unsigned BEAT_W = OUT_LANES * LANE_W;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // -----------------------------------------------------------------------
    // Lane masking at enqueue
    // -----------------------------------------------------------------------
    logic [NUM_LANES-1:0][LANE_W-1:0] mu_lanes;
    logic [NUM_LANES-1:0][LANE_W-1:0] wr_lanes;

    assign mu_lanes = mu_dat;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mu2cgra_lane_mask #(
            .LANE_W (LANE_W)
        ) u_mask (
            .lane_i (mu_lanes[i]),
            .en_i   (cfg_lane_mask[i]),
            .lane_o (wr_lanes[i])
        );
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WORD_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [BIDX_W-1:0]  beat_q,   beat_d;
    logic [STALL_W-1:0] stall_q,  stall_d;

    logic push;
    logic pop;
    logic beat_fire;
    logic last_beat;

    // Pointers wrap at DEPTH explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy: space freed by a pop shows
    // up one cycle later, keeping cgra_rdy off the mu_rdy path.
    assign mu_rdy    = (count_q < CNT_W'(DEPTH));
    assign cgra_vld  = (count_q != '0);
    assign push      = mu_vld & mu_rdy;
    assign beat_fire = cgra_vld & cgra_rdy;
    assign pop       = beat_fire & last_beat;

    // -----------------------------------------------------------------------
    // Head word beat selection
    // -----------------------------------------------------------------------
    logic [BEATS-1:0][BEAT_W-1:0] head_beats;
    logic [BEAT_W-1:0]            beat_dat;

    assign head_beats = mem_q[rd_ptr_q];

    if (BEATS == 1) begin : g_single
        assign last_beat = 1'b1;
        assign beat_dat  = head_beats[0];
    end else begin : g_multi
        assign last_beat = (beat_q == BIDX_W'(BEATS - 1));
        assign beat_dat  = head_beats[beat_q];
    end

    // Storage contents are stale when empty, so gate the output to zero.
    assign cgra_dat      = cgra_vld ? beat_dat : '0;
    assign cgra_beat_idx = beat_q;
    assign cgra_last     = last_beat;
    assign fifo_count    = count_q;
    assign stall_cycles  = stall_q;

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        stall_d  = stall_q;

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Beat advances only on an accepted beat; otherwise the beat and its
        // data are held while the CGRA stalls.
        if (beat_fire) beat_d = last_beat ? '0 : beat_q + 1'b1;

        // Clear wins over increment; increment stops at all-ones.
        if (stat_clr)
            stall_d = '0;
        else if (cgra_vld && !cgra_rdy && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            stall_q  <= stall_d;
        end
    end

    // Word storage: no reset, written with the masked word on push.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= wr_lanes;
    end

endmodule

// File: tb/tb_mu2cgra_lane_bridge.sv
// ---------------------------------------------------------------------------
// tb_mu2cgra_lane_bridge
//
// Two bridge instances share clock and reset:
//   A: defaults (32 lanes x 16b, DEPTH 4, single beat, 32-bit stall counter)
//   B: OUT_LANES 8 (4 beats/word), DEPTH 3, 4-bit stall counter
// Each instance has a scoreboard queue fed at the push handshake and drained
// at each accepted beat. Scenario tasks drive stimulus and add their own
// targeted checks. Inputs change 1ns after the rising edge; the scoreboard
// samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_mu2cgra_lane_bridge;
    localparam int NL = 32;
    localparam int LW = 16;
    localparam int WW = NL * LW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A signals
    logic [WW-1:0]  a_mu_dat;
    logic           a_mu_vld, a_mu_rdy;
    logic [NL-1:0]  a_mask;
    logic [WW-1:0]  a_cgra_dat;
    logic           a_cgra_vld, a_cgra_rdy;
    logic [0:0]     a_idx;
    logic           a_last;
    logic [2:0]     a_cnt;
    logic           a_clr;
    logic [31:0]    a_stall;

    // Instance B signals
    logic [WW-1:0]  b_mu_dat;
    logic           b_mu_vld, b_mu_rdy;
    logic [NL-1:0]  b_mask;
    logic [127:0]   b_cgra_dat;
    logic           b_cgra_vld, b_cgra_rdy;
    logic [1:0]     b_idx;
    logic           b_last;
    logic [1:0]     b_cnt;
    logic           b_clr;
    logic [3:0]     b_stall;

    mu2cgra_lane_bridge u_a (
        .clk_in(clk), .reset_in(rst),
        .mu_dat(a_mu_dat), .mu_vld(a_mu_vld), .mu_rdy(a_mu_rdy),
        .cfg_lane_mask(a_mask),
        .cgra_dat(a_cgra_dat), .cgra_vld(a_cgra_vld), .cgra_rdy(a_cgra_rdy),
        .cgra_beat_idx(a_idx), .cgra_last(a_last), .fifo_count(a_cnt),
        .stat_clr(a_clr), .stall_cycles(a_stall)
    );

    mu2cgra_lane_bridge #(
        .NUM_LANES(32), .LANE_W(16), .DEPTH(3), .OUT_LANES(8), .STALL_W(4)
    ) u_b (
        .clk_in(clk), .reset_in(rst),
        .mu_dat(b_mu_dat), .mu_vld(b_mu_vld), .mu_rdy(b_mu_rdy),
        .cfg_lane_mask(b_mask),
        .cgra_dat(b_cgra_dat), .cgra_vld(b_cgra_vld), .cgra_rdy(b_cgra_rdy),
        .cgra_beat_idx(b_idx), .cgra_last(b_last), .fifo_count(b_cnt),
        .stat_clr(b_clr), .stall_cycles(b_stall)
    );

    // ---------------- reference helpers ----------------
    function automatic logic [WW-1:0] ramp(input int base);
        logic [WW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*LW +: LW] = 16'(base + i);
        return r;
    endfunction

    function automatic logic [WW-1:0] mask_word(input logic [WW-1:0] w, input logic [NL-1:0] m);
        logic [WW-1:0] r;
        r = w;
        for (int i = 0; i < NL; i++) if (!m[i]) r[i*LW +: LW] = '0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [127:0] dat;
        logic [1:0]   idx;
        logic         last;
    } beat_t;

    logic [WW-1:0] qa[$];
    beat_t         qb[$];

    always @(negedge clk) begin : mon_a
        if (rst) qa.delete();
        else begin
            n_checks++;
            if (a_cgra_vld !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL a_vld: got %0b exp %0b", a_cgra_vld, qa.size() != 0);
            end
            if (a_cgra_vld && qa.size() != 0) begin
                n_checks++;
                if ({a_cgra_dat, a_idx, a_last} !== {qa[0], 1'b0, 1'b1}) begin
                    n_fail++; $display("FAIL a_beat: got %h/%0d/%0b exp %h/0/1", a_cgra_dat, a_idx, a_last, qa[0]);
                end
                if (a_cgra_rdy) void'(qa.pop_front());
            end
            if (a_mu_vld && a_mu_rdy) qa.push_back(mask_word(a_mu_dat, a_mask));
        end
    end

    always @(negedge clk) begin : mon_b
        logic [WW-1:0] mw;
        beat_t e;
        if (rst) qb.delete();
        else begin
            n_checks++;
            if (b_cgra_vld !== (qb.size() != 0)) begin
                n_fail++; $display("FAIL b_vld: got %0b exp %0b", b_cgra_vld, qb.size() != 0);
            end
            if (b_cgra_vld && qb.size() != 0) begin
                n_checks++;
                if ({b_cgra_dat, b_idx, b_last} !== {qb[0].dat, qb[0].idx, qb[0].last}) begin
                    n_fail++; $display("FAIL b_beat: got %h/%0d/%0b exp %h/%0d/%0b",
                                       b_cgra_dat, b_idx, b_last, qb[0].dat, qb[0].idx, qb[0].last);
                end
                if (b_cgra_rdy) void'(qb.pop_front());
            end
            if (b_mu_vld && b_mu_rdy) begin
                mw = mask_word(b_mu_dat, b_mask);
                for (int bt = 0; bt < 4; bt++) begin
                    e.dat  = mw[bt*128 +: 128];
                    e.idx  = 2'(bt);
                    e.last = (bt == 3);
                    qb.push_back(e);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({a_mu_rdy, a_cgra_vld, a_idx, a_last, a_cnt, a_stall} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0}) begin
            n_fail++; $display("FAIL rst_a: got rdy=%0b vld=%0b idx=%0d last=%0b cnt=%0d stall=%0d exp 1 0 0 1 0 0",
                               a_mu_rdy, a_cgra_vld, a_idx, a_last, a_cnt, a_stall);
        end
        n_checks++;
        if ({b_mu_rdy, b_cgra_vld, b_idx, b_last, b_cnt, b_stall} !== {1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0}) begin
            n_fail++; $display("FAIL rst_b: got rdy=%0b vld=%0b idx=%0d last=%0b cnt=%0d stall=%0d exp 1 0 0 0 0 0",
                               b_mu_rdy, b_cgra_vld, b_idx, b_last, b_cnt, b_stall);
        end
        n_checks++;
        if (a_cgra_dat !== '0 || b_cgra_dat !== '0) begin
            n_fail++; $display("FAIL rst_dat: got a=%h b=%h exp 0", a_cgra_dat, b_cgra_dat);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [WW-1:0] w;
        a_cgra_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = ramp(16'h100 + k * 64);
            a_mu_dat = w;
            a_mu_vld = 1'b1;
            tick();
            n_checks++;
            if ({a_cgra_vld, a_cnt} !== {1'b1, 3'd1}) begin
                n_fail++; $display("FAIL stream_occ: got vld=%0b cnt=%0d exp 1 1", a_cgra_vld, a_cnt);
            end
            n_checks++;
            if (a_cgra_dat !== w) begin
                n_fail++; $display("FAIL stream_dat: got %h exp %h", a_cgra_dat, w);
            end
            if (k == 0) begin
                n_checks++;
                if (a_cgra_dat[511:496] !== 16'h011F) begin
                    n_fail++; $display("FAIL stream_lane31: got %h exp 011f", a_cgra_dat[511:496]);
                end
            end
        end
        a_mu_vld = 1'b0;
        tick();
        n_checks++;
        if ({a_cgra_vld, a_cnt, a_stall} !== {1'b0, 3'd0, 32'd0}) begin
            n_fail++; $display("FAIL stream_end: got vld=%0b cnt=%0d stall=%0d exp 0 0 0", a_cgra_vld, a_cnt, a_stall);
        end
    endtask

    task automatic test_backpressure();
        int  k;
        logic acc;
        k = 0;
        a_cgra_rdy = 1'b0;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        for (int it = 0; it < 11; it++) begin
            a_mu_dat = ramp(16'h400 + k * 64);
            a_mu_vld = 1'b1;
            acc = a_mu_rdy;
            tick();
            if (acc) k++;
        end
        n_checks++;
        if (k != 4 || a_mu_rdy !== 1'b0 || a_cnt !== 3'd4) begin
            n_fail++; $display("FAIL bp_full: got pushes=%0d rdy=%0b cnt=%0d exp 4 0 4", k, a_mu_rdy, a_cnt);
        end
        n_checks++;
        if (a_stall !== 32'd10) begin
            n_fail++; $display("FAIL bp_stall: got %0d exp 10", a_stall);
        end
        a_cgra_rdy = 1'b1;
        tick();
        n_checks++;
        if ({a_mu_rdy, a_cnt} !== {1'b1, 3'd3}) begin
            n_fail++; $display("FAIL bp_rdy_back: got rdy=%0b cnt=%0d exp 1 3", a_mu_rdy, a_cnt);
        end
        tick();
        a_mu_vld = 1'b0;
        repeat (5) tick();
        n_checks++;
        if ({a_cnt, a_stall} !== {3'd0, 32'd10}) begin
            n_fail++; $display("FAIL bp_drain: got cnt=%0d stall=%0d exp 0 10", a_cnt, a_stall);
        end
    endtask

    task automatic test_mask();
        logic [WW-1:0] exp_w;
        exp_w = {{16{16'hFFFF}}, {16{16'h0000}}};
        a_cgra_rdy = 1'b0;
        a_mask   = 32'hFFFF_0000;
        a_mu_dat = '1;
        a_mu_vld = 1'b1;
        tick();
        a_mu_vld = 1'b0;
        a_mask   = '1;
        tick();
        n_checks++;
        if (a_cgra_dat !== exp_w) begin
            n_fail++; $display("FAIL mask_dat: got %h exp %h", a_cgra_dat, exp_w);
        end
        a_cgra_rdy = 1'b1;
        tick();
        n_checks++;
        if (a_cnt !== 3'd0) begin
            n_fail++; $display("FAIL mask_drain: got cnt=%0d exp 0", a_cnt);
        end
    endtask

    task automatic test_serialise();
        logic [127:0] exp_b;
        b_cgra_rdy = 1'b1;
        b_mu_dat = ramp(0);
        b_mu_vld = 1'b1;
        tick();
        b_mu_vld = 1'b0;
        for (int bt = 0; bt < 4; bt++) begin
            for (int j = 0; j < 8; j++) exp_b[j*16 +: 16] = 16'(bt * 8 + j);
            n_checks++;
            if (b_cgra_dat !== exp_b) begin
                n_fail++; $display("FAIL ser_dat%0d: got %h exp %h", bt, b_cgra_dat, exp_b);
            end
            n_checks++;
            if ({b_idx, b_last, b_cnt} !== {2'(bt), (bt == 3), 2'd1}) begin
                n_fail++; $display("FAIL ser_ctl%0d: got idx=%0d last=%0b cnt=%0d exp %0d %0b 1",
                                   bt, b_idx, b_last, b_cnt, bt, bt == 3);
            end
            tick();
        end
        n_checks++;
        if ({b_cgra_vld, b_cnt} !== {1'b0, 2'd0}) begin
            n_fail++; $display("FAIL ser_pop: got vld=%0b cnt=%0d exp 0 0", b_cgra_vld, b_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] d;
        for (int c = 0; c < 80; c++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            b_mu_dat   = d;
            b_mu_vld   = 1'($urandom_range(0, 1));
            b_mask     = $urandom;
            b_cgra_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        b_mu_vld   = 1'b0;
        b_cgra_rdy = 1'b1;
        b_mask     = '1;
        repeat (16) tick();
        n_checks++;
        if (b_cnt !== 2'd0) begin
            n_fail++; $display("FAIL b2b_drain: got cnt=%0d exp 0", b_cnt);
        end
    endtask

    task automatic test_saturate();
        b_cgra_rdy = 1'b0;
        b_clr      = 1'b1;
        b_mu_dat   = ramp(16'h300);
        b_mu_vld   = 1'b1;
        tick();
        b_mu_vld = 1'b0;
        b_clr    = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (b_stall !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d exp 15", b_stall);
        end
        b_clr = 1'b1;
        tick();
        n_checks++;
        if (b_stall !== 4'd0) begin
            n_fail++; $display("FAIL sat_clr: got %0d exp 0", b_stall);
        end
        b_clr = 1'b0;
        tick();
        n_checks++;
        if (b_stall !== 4'd1) begin
            n_fail++; $display("FAIL sat_restart: got %0d exp 1", b_stall);
        end
        b_cgra_rdy = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (b_cnt !== 2'd0) begin
            n_fail++; $display("FAIL sat_drain: got cnt=%0d exp 0", b_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w;
        b_cgra_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_mu_dat = ramp(16'h500 + k * 32);
            b_mu_vld = 1'b1;
            tick();
        end
        b_mu_vld   = 1'b0;
        b_cgra_rdy = 1'b1;
        repeat (2) tick();
        b_cgra_rdy = 1'b0;
        n_checks++;
        if ({b_idx, b_cnt} !== {2'd2, 2'd3}) begin
            n_fail++; $display("FAIL rmid_pre: got idx=%0d cnt=%0d exp 2 3", b_idx, b_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({b_cgra_vld, b_cnt, b_idx, b_mu_rdy} !== {1'b0, 2'd0, 2'd0, 1'b1}) begin
            n_fail++; $display("FAIL rmid_async: got vld=%0b cnt=%0d idx=%0d rdy=%0b exp 0 0 0 1",
                               b_cgra_vld, b_cnt, b_idx, b_mu_rdy);
        end
        n_checks++;
        if (b_cgra_dat !== '0) begin
            n_fail++; $display("FAIL rmid_dat: got %h exp 0", b_cgra_dat);
        end
        tick();
        rst = 1'b0;
        w = ramp(16'h600);
        b_cgra_rdy = 1'b1;
        b_mu_dat   = w;
        b_mu_vld   = 1'b1;
        tick();
        b_mu_vld = 1'b0;
        n_checks++;
        if ({b_idx, b_cgra_dat} !== {2'd0, w[127:0]}) begin
            n_fail++; $display("FAIL rmid_next: got idx=%0d dat=%h exp 0 %h", b_idx, b_cgra_dat, w[127:0]);
        end
        repeat (4) tick();
        n_checks++;
        if (b_cnt !== 2'd0) begin
            n_fail++; $display("FAIL rmid_drain: got cnt=%0d exp 0", b_cnt);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        a_mu_dat = '0; a_mu_vld = 1'b0; a_mask = '1; a_cgra_rdy = 1'b0; a_clr = 1'b0;
        b_mu_dat = '0; b_mu_vld = 1'b0; b_mask = '1; b_cgra_rdy = 1'b0; b_clr = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_mask();
        test_serialise();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        repeat (3) tick();
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++; $display("FAIL sb_empty: got a=%0d b=%0d pending exp 0 0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mu2cgra_lane_bridge.md
Name: mu2cgra_lane_bridge

Overview:
- Parametrised buffered bridge between the matrix unit's fused systolic-array output (NUM_LANES lanes × LANE_W bits, valid/ready) and the CGRA tile-array input lanes.
- Replaces the direct flat-bus-to-lane split with:
  - a DEPTH-entry word FIFO,
  - optional serialisation of each wide word into narrower beats (OUT_LANES lanes per beat),
  - a per-lane zeroing mask,
  - a backpressure stall counter for performance debug.
- Sits between MatrixUnitWrapper and Garnet in the Zircon top level.

Parameters:
- NUM_LANES, 32, lanes per matrix-unit output word.
- LANE_W, 16, bits per lane.
- DEPTH, 4, FIFO depth in full words; must be ≥1.
- OUT_LANES, 32, lanes per CGRA beat. Must divide NUM_LANES. BEATS = NUM_LANES/OUT_LANES.
- STALL_W, 32, stall counter width.

Ports:
- clk_in  in  1  clock.
- reset_in  in  1  reset; asynchronous, active-high.
- mu_dat  in  NUM_LANES*LANE_W  MU word; lane i occupies bits [(i+1)*LANE_W-1 : i*LANE_W].
- mu_vld  in  1  MU word valid.
- mu_rdy  out  1  bridge can accept a word.
- cfg_lane_mask  in  NUM_LANES  1 = lane passes, 0 = lane forced to zero.
- cgra_dat  out  OUT_LANES*LANE_W  current beat; lane j at bits [(j+1)*LANE_W-1 : j*LANE_W].
- cgra_vld  out  1  beat valid.
- cgra_rdy  in  1  CGRA accepts beat.
- cgra_beat_idx  out  clog2(BEATS) (min 1)  index of the current beat within its word.
- cgra_last  out  1  current beat is the final beat of its word.
- fifo_count  out  clog2(DEPTH+1)  words held.
- stat_clr  in  1  synchronous clear of stall counter.
- stall_cycles  out  STALL_W  count of cycles with cgra_vld=1 and cgra_rdy=0.

Behaviour:
- Reset (async assert, sync-safe release):
  - fifo_count=0, read/write pointers=0, beat counter=0, stall_cycles=0.
  - Consequently mu_rdy=1, cgra_vld=0, cgra_dat=0, cgra_beat_idx=0, cgra_last=(BEATS==1).
- FIFO storage is not reset. Reset mid-transfer discards all buffered words and any partially sent word; no beat is replayed.
- Enqueue:
  - Push occurs on a clock edge when mu_vld & mu_rdy.
  - mu_rdy = (fifo_count < DEPTH). It is registered-state only, with no combinational path from cgra_rdy.
  - The stored word is mu_dat with lane i zeroed where cfg_lane_mask[i]=0, sampled at the push edge. Mask changes affect only later pushes.
- Output:
  - cgra_vld = (fifo_count != 0).
  - cgra_dat = lanes [beat*OUT_LANES .. beat*OUT_LANES+OUT_LANES-1] of the head word. It is zero whenever cgra_vld=0.
  - cgra_last = (beat == BEATS-1).
- Beat handshake: a beat transfers when cgra_vld & cgra_rdy.
  - If not last: beat increments and the head word is held.
  - If last: beat returns to 0 and the head is popped.
- Latency: a word pushed at edge t is presented at beat 0 from t+1 when the FIFO was empty. There is no same-cycle bypass.
- Push and pop on the same edge: fifo_count is unchanged and both pointers advance.
  - At full, push cannot occur because mu_rdy=0. Space freed by a pop is visible the next cycle.
  - At empty, pop cannot occur.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Holding rule: cgra_dat and cgra_beat_idx must stay stable while cgra_vld=1 and cgra_rdy=0.
- Stall counter:
  - Increments on each cycle with cgra_vld & !cgra_rdy.
  - Saturates at all-ones and does not wrap.
  - stat_clr=1 forces 0 on the next edge and has priority over increment.
- BEATS==1 (default): the block degenerates to a FIFO; cgra_last is constantly 1 and cgra_beat_idx is constantly 0.

Test Plan:
- Default params, cgra_rdy=1: push words with lane i = i+0x100 → each word appears the cycle after its push; lane 31 = 0x011F at bits [511:496]; stall_cycles stays 0.
- DEPTH=4, cgra_rdy=0: hold mu_vld=1 → exactly 4 pushes, then mu_rdy=0, fifo_count=4. After 10 stalled cycles, stall_cycles=10. Raise cgra_rdy → words drain in order and mu_rdy returns the cycle after the first pop.
- OUT_LANES=8 (BEATS=4): push one word with lane i = i → beats 0..3 carry lanes 0-7, 8-15, 16-23, 24-31. cgra_last=1 only on beat 3, and the pop happens after beat 3.
- cfg_lane_mask=0xFFFF0000: push a word of all 0xFFFF lanes → lanes 0-15 read 0x0000 and lanes 16-31 read 0xFFFF. Changing the mask after the push leaves that word unaltered.
- Assert reset_in asynchronously mid-word, e.g. at BEATS=4 beat 2 with fifo_count=3 → cgra_vld=0, fifo_count=0, beat_idx=0 and mu_rdy=1 immediately. The next pushed word starts at beat 0.
- Force stall_cycles to saturation using STALL_W=4: 20 stall cycles → value held at 15. Assert stat_clr together with a stall → 0 next cycle.
